// File: rtl/updown_step_sequencer_pkg.sv
// updown_seq_pkg: state encoding, direction constants and default widths for the step sequencer
package updown_seq_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10} state_t;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DOWN = 1'b0;
  localparam int CNT_W_DEF = 3;
  localparam int STEP_W_DEF = 4;
endpackage

// File: rtl/updown_step_sequencer_if.sv
// updown_step_sequencer_if: valid/ready command channel carrying {direction, step count}
interface updown_step_sequencer_if #(parameter int STEP_W = 4);
  logic cmd_valid;
  logic cmd_ready;
  logic cmd_dir;
  logic [STEP_W-1:0] cmd_steps;
  modport master (output cmd_valid, cmd_dir, cmd_steps, input cmd_ready);
  modport slave (input cmd_valid, cmd_dir, cmd_steps, output cmd_ready);
endinterface

// File: rtl/ud_counter_dp.sv
// ud_counter_dp: wrapping up/down counter with display code; GRAY_CODE_EN selects a registered Gray code
module ud_counter_dp #(parameter int CNT_W = 3) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic up,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] code
);
  logic [CNT_W-1:0] nxt;
  assign nxt = en ? (up ? count + CNT_W'(1) : count - CNT_W'(1)) : count;
  always_ff @(posedge clk or posedge reset)
    if (reset) count <= '0;
    else count <= nxt;
`ifdef GRAY_CODE_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) code <= '0;
    else code <= nxt ^ (nxt >> 1);
`else
  assign code = count;
`endif
endmodule

// File: rtl/updown_step_sequencer.sv
// updown_step_sequencer: accepts {dir, steps} commands and steps a counter once per clock until exhausted; GRAY_CODE_EN selects Gray display code
module updown_step_sequencer
  import updown_seq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int STEP_W = STEP_W_DEF
) (
  input  logic clk,
  input  logic reset,
  updown_step_sequencer_if.slave cmd,
  input  logic abort,
  output logic busy,
  output logic done,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] code
);
  state_t state, state_nxt;
  logic [STEP_W-1:0] remaining, rem_nxt;
  logic dir, dir_nxt, step;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      remaining <= '0;
      dir <= DIR_DOWN;
    end else begin
      state <= state_nxt;
      remaining <= rem_nxt;
      dir <= dir_nxt;
    end
  // Unlisted encodings (2'b11) fall to the default and recover to IDLE
  always_comb begin
    state_nxt = IDLE;
    rem_nxt = remaining;
    dir_nxt = dir;
    step = 1'b0;
    case (state)
      IDLE: if (cmd.cmd_valid) begin
        dir_nxt = cmd.cmd_dir;
        rem_nxt = cmd.cmd_steps;
        state_nxt = cmd.cmd_steps == '0 ? DONE : RUN;
      end
      RUN: if (abort) rem_nxt = '0;
      else begin
        step = 1'b1;
        rem_nxt = remaining - STEP_W'(1);
        state_nxt = remaining == STEP_W'(1) ? DONE : RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end
  assign cmd.cmd_ready = state == IDLE;
  assign busy = state == RUN || state == DONE;
  assign done = state == DONE;
  ud_counter_dp #(.CNT_W(CNT_W)) u_dp (
    .clk(clk),
    .reset(reset),
    .en(step),
    .up(dir == DIR_UP),
    .count(count),
    .code(code)
  );
endmodule
